// File: rtl/mem_copy_engine.sv
// mem_copy_engine: word copy engine driving DataMemory, 2 cycles/word.
// Defining MEM_COPY_FILL_EN adds a fill mode (Fill/FillValue) writing one word per cycle.
module mem_copy_engine #(
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [31:0]      SrcAddr,
  input  logic [31:0]      DstAddr,
  input  logic [CNT_W-1:0] WordCount,
`ifdef MEM_COPY_FILL_EN
  input  logic             Fill,
  input  logic [31:0]      FillValue,
`endif
  output logic             Busy,
  output logic             Done,
  output logic             Error,
  output logic [CNT_W-1:0] WordsCopied,
  output logic [31:0]      Address,
  output logic [31:0]      WriteData,
  output logic             MemWrite,
  output logic             MemRead,
  input  logic [31:0]      ReadData
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  state_t           r_state;
  logic [31:0]      r_src, r_dst, r_buf, r_fill_val;
  logic [CNT_W-1:0] r_cnt;
  logic             r_fill;
  logic             w_fill;
  logic [31:0]      w_fill_val;
  logic             w_aligned, w_last;
`ifdef MEM_COPY_FILL_EN
  assign w_fill     = Fill;
  assign w_fill_val = FillValue;
`else
  assign w_fill     = 1'b0;
  assign w_fill_val = '0;
`endif
  assign w_aligned = SrcAddr[1:0] == 2'b00 && DstAddr[1:0] == 2'b00;
  assign w_last    = WordsCopied + CNT_W'(1) == r_cnt;
  // Strobes/address are registered for the state being entered, so they line up with r_state.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state     <= IDLE;
      r_src       <= '0;
      r_dst       <= '0;
      r_buf       <= '0;
      r_cnt       <= '0;
      r_fill      <= 1'b0;
      r_fill_val  <= '0;
      Busy        <= 1'b0;
      Done        <= 1'b0;
      Error       <= 1'b0;
      WordsCopied <= '0;
      Address     <= '0;
      WriteData   <= '0;
      MemWrite    <= 1'b0;
      MemRead     <= 1'b0;
    end else begin
      Done      <= 1'b0;
      Error     <= 1'b0;
      MemRead   <= 1'b0;
      MemWrite  <= 1'b0;
      Address   <= '0;
      WriteData <= '0;
      case (r_state)
        IDLE: if (Start) begin
          if (!w_aligned) Error <= 1'b1;
          else begin
            r_src       <= SrcAddr;
            r_dst       <= DstAddr;
            r_cnt       <= WordCount;
            r_fill      <= w_fill;
            r_fill_val  <= w_fill_val;
            WordsCopied <= '0;
            Busy        <= 1'b1;
            if (WordCount == '0) begin
              r_state <= DONE;
              Done    <= 1'b1;
            end else if (w_fill) begin
              r_state   <= WRITE;
              MemWrite  <= 1'b1;
              Address   <= DstAddr;
              WriteData <= w_fill_val;
            end else begin
              r_state <= READ;
              MemRead <= 1'b1;
              Address <= SrcAddr;
            end
          end
        end
        READ: begin
          r_buf     <= ReadData;
          r_state   <= WRITE;
          MemWrite  <= 1'b1;
          Address   <= r_dst;
          WriteData <= ReadData;
        end
        WRITE: begin
          r_src       <= r_src + 32'd4;
          r_dst       <= r_dst + 32'd4;
          WordsCopied <= WordsCopied + CNT_W'(1);
          if (w_last) begin
            r_state <= DONE;
            Done    <= 1'b1;
          end else if (r_fill) begin
            MemWrite  <= 1'b1;
            Address   <= r_dst + 32'd4;
            WriteData <= r_fill_val;
          end else begin
            r_state <= READ;
            MemRead <= 1'b1;
            Address <= r_src + 32'd4;
          end
        end
        default: begin
          r_state <= IDLE;
          Busy    <= 1'b0;
        end
      endcase
    end
  end
endmodule
